// File: rtl/vdic_alu_stream_if.sv
// vdic_alu_stream_if: handshake bundle for the frame ALU.
// Command/operand beats flow in, one result per frame flows out.
interface vdic_alu_stream_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 2 * DATA_W
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  res_data;
    logic [3:0]        res_status;
    modport master (
        output in_valid, in_data, in_last, res_ready,
        input  in_ready, res_valid, res_data, res_status
    );
    modport slave (
        input  in_valid, in_data, in_last, res_ready,
        output in_ready, res_valid, res_data, res_status
    );
endinterface

// File: rtl/vdic_alu_stream.sv
// vdic_alu_stream: framed streaming ALU folding up to MAX_OPS operands per command.
// res_status = {ZERO, CARRY, ERR_SIZE, ERR_CMD}.
module vdic_alu_stream #(
    parameter int DATA_W  = 8,
    parameter int MAX_OPS = 9,
    parameter int ACC_W   = 2 * DATA_W
) (
    input logic              clk,
    input logic              rst_n,
    vdic_alu_stream_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_OPS + 1);
    localparam logic [2:0] OP_NOP = 3'd0, OP_ADD = 3'd1, OP_AND = 3'd2, OP_XOR = 3'd3;
    localparam logic [2:0] OP_OR = 3'd4, OP_SUB = 3'd5, OP_MAX = 3'd6, OP_BAD = 3'd7;
    typedef enum logic [1:0] {IDLE, DATA, DRAIN, RESP} state_t;
    state_t           state_q, state_d;
    logic             ready_q, ready_d;
    logic [2:0]       op_q, op_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_cmd_q, err_cmd_d, err_size_q, err_size_d, carry_q, carry_d;
    logic [ACC_W-1:0] opnd, comb;
    logic [ACC_W:0]   sum;
    logic             fire, full, err, resp;
    // ready_q keeps in_ready low until the first edge after reset release
    assign bus.in_ready = ready_q && state_q != RESP;
    assign fire = bus.in_valid && bus.in_ready;
    assign opnd = ACC_W'(bus.in_data);
    assign sum  = {1'b0, acc_q} + {1'b0, opnd};
    assign full = cnt_q == CNT_W'(MAX_OPS);
    assign comb = op_q == OP_ADD ? sum[ACC_W-1:0] :
                  op_q == OP_AND ? acc_q & opnd :
                  op_q == OP_XOR ? acc_q ^ opnd :
                  op_q == OP_OR  ? acc_q | opnd :
                  op_q == OP_SUB ? acc_q - opnd :
                  op_q == OP_MAX ? (opnd > acc_q ? opnd : acc_q) : '0;
    assign err  = err_cmd_q || err_size_q;
    assign resp = state_q == RESP;
    assign bus.res_valid  = resp;
    assign bus.res_data   = resp && !err ? acc_q : '0;
    assign bus.res_status = resp ? {!err && acc_q == '0, !err && carry_q, err_size_q, err_cmd_q} : 4'b0;
    always_comb begin
        state_d    = state_q;
        ready_d    = 1'b1;
        op_d       = op_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        err_cmd_d  = err_cmd_q;
        err_size_d = err_size_q;
        carry_d    = carry_q;
        case (state_q)
            IDLE: if (fire) begin
                op_d       = bus.in_data[2:0];
                acc_d      = '0;
                cnt_d      = '0;
                carry_d    = 1'b0;
                err_cmd_d  = bus.in_data[2:0] == OP_BAD;
                err_size_d = bus.in_last;
                state_d    = bus.in_last ? RESP : DATA;
            end
            DATA: if (fire) begin
                if (full) begin
                    err_size_d = 1'b1;
                    state_d    = bus.in_last ? RESP : DRAIN;
                end else begin
                    acc_d   = cnt_q == '0 ? (op_q == OP_NOP ? '0 : opnd) : comb;
                    carry_d = carry_q || (cnt_q != '0 && ((op_q == OP_ADD && sum[ACC_W]) ||
                                                          (op_q == OP_SUB && opnd > acc_q)));
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = bus.in_last ? RESP : DATA;
                end
            end
            DRAIN: if (fire && bus.in_last) state_d = RESP;
            default: if (bus.res_ready) state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ready_q    <= 1'b0;
            op_q       <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            err_cmd_q  <= 1'b0;
            err_size_q <= 1'b0;
            carry_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            op_q       <= op_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            err_cmd_q  <= err_cmd_d;
            err_size_q <= err_size_d;
            carry_q    <= carry_d;
        end
    end
endmodule

// File: tb/tb_vdic_alu_stream.sv
// tb_vdic_alu_stream: table vectors, reset/backpressure sequences and
// random frames checked against an arithmetic reference model.
module tb_vdic_alu_stream;
    localparam int DATA_W = 8, MAX_OPS = 9, ACC_W = 16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    vdic_alu_stream_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();
    vdic_alu_stream #(.DATA_W(DATA_W), .MAX_OPS(MAX_OPS), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    int n_vec = 0, n_bad = 0;
    typedef struct packed {
        logic [2:0]       op;
        logic [3:0]       n;
        logic [11:0][7:0] ops;
        logic [15:0]      exp_data;
        logic [3:0]       exp_status;
    } vec_t;
    vec_t vecs[13];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // result = fold of operands with 16-bit wraparound; status {ZERO,CARRY,ERR_SIZE,ERR_CMD}
    function automatic logic [19:0] model(logic [2:0] op, int n, logic [11:0][7:0] ops);
        int acc = 0;
        bit carry = 0;
        logic [3:0] errs = {2'b00, n == 0 || n > MAX_OPS, op == 3'd7};
        if (errs != 4'b0) return {16'h0, errs};
        for (int i = 0; i < n; i++) begin
            int x = int'(ops[i]);
            if (i == 0) acc = (op == 3'd0) ? 0 : x;
            else case (op)
                3'd1: begin carry |= (acc + x > 65535); acc = (acc + x) % 65536; end
                3'd2: acc = acc & x;
                3'd3: acc = acc ^ x;
                3'd4: acc = acc | x;
                3'd5: begin carry |= (x > acc); acc = (acc - x + 65536) % 65536; end
                3'd6: acc = (x > acc) ? x : acc;
                default: acc = 0;
            endcase
        end
        return {acc[15:0], acc == 0, carry, 2'b00};
    endfunction

    task automatic beat(logic [7:0] d, logic last, int gap);
        int t = 0;
        repeat (gap) begin @(posedge clk); #1; end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        @(negedge clk);
        while (!bus.in_ready && t < 20) begin @(negedge clk); t++; end
        if (t >= 20) begin
            n_vec++; n_bad++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_frame(logic [2:0] op, int n, logic [11:0][7:0] ops, int max_gap);
        beat({5'($urandom_range(0, 31)), op}, n == 0, $urandom_range(0, max_gap));
        for (int i = 0; i < n; i++) beat(ops[i], i == n - 1, $urandom_range(0, max_gap));
    endtask

    task automatic get_result(string name, logic [15:0] ed, logic [3:0] es, int hold);
        chk({name, "_latency"}, 32'(bus.res_valid), 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({name, "_hold_valid"}, 32'(bus.res_valid), 32'd1);
            chk({name, "_hold_data"}, 32'(bus.res_data), 32'(ed));
            chk({name, "_hold_status"}, 32'(bus.res_status), 32'(es));
            chk({name, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        @(negedge clk);
        chk({name, "_data"}, 32'(bus.res_data), 32'(ed));
        chk({name, "_status"}, 32'(bus.res_status), 32'(es));
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        chk({name, "_released"}, 32'(bus.res_valid), 32'd0);
    endtask

    task automatic check_reset_outputs(string name);
        chk({name, "_valid"}, 32'(bus.res_valid), 32'd0);
        chk({name, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        chk({name, "_data"}, 32'(bus.res_data), 32'd0);
        chk({name, "_status"}, 32'(bus.res_status), 32'd0);
    endtask

    task automatic pulse_reset(string name);
        rst_n = 1'b0;
        #1;
        check_reset_outputs(name);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk({name, "_ready_before_edge"}, 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        chk({name, "_ready_after_edge"}, 32'(bus.in_ready), 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk({name, "_no_result"}, 32'(bus.res_valid), 32'd0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [19:0] m;
        logic [11:0][7:0] r_ops;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.res_ready = 1'b0;
        vecs[0]  = '{3'd1, 4'd9,  {12{8'hFF}},  16'h08F7, 4'b0000};
        vecs[1]  = '{3'd5, 4'd2,  96'h0705,     16'hFFFE, 4'b0100};
        vecs[2]  = '{3'd3, 4'd2,  96'hAAAA,     16'h0000, 4'b1000};
        vecs[3]  = '{3'd1, 4'd10, {12{8'h01}},  16'h0000, 4'b0010};
        vecs[4]  = '{3'd1, 4'd0,  96'h0,        16'h0000, 4'b0010};
        vecs[5]  = '{3'd7, 4'd2,  96'h1234,     16'h0000, 4'b0001};
        vecs[6]  = '{3'd1, 4'd2,  96'h0201,     16'h0003, 4'b0000};
        vecs[7]  = '{3'd6, 4'd3,  96'h037F10,   16'h007F, 4'b0000};
        vecs[8]  = '{3'd5, 4'd3,  96'h200310,   16'hFFED, 4'b0100};
        vecs[9]  = '{3'd2, 4'd2,  96'h3CF0,     16'h0030, 4'b0000};
        vecs[10] = '{3'd4, 4'd2,  96'h8001,     16'h0081, 4'b0000};
        vecs[11] = '{3'd0, 4'd1,  96'h05,       16'h0000, 4'b1000};
        vecs[12] = '{3'd1, 4'd12, {12{8'h22}},  16'h0000, 4'b0010};
        #1;
        check_reset_outputs("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_ready_before_edge", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        chk("reset_ready_after_edge", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 13; i++) begin
            send_frame(vecs[i].op, int'(vecs[i].n), vecs[i].ops, 0);
            get_result($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_status, 0);
        end
        send_frame(3'd1, 2, 96'h0201, 0);
        get_result("backpressure", 16'h0003, 4'b0000, 5);
        beat(8'h01, 1'b0, 0);
        for (int i = 0; i < 3; i++) beat(8'(i + 1), 1'b0, 0);
        pulse_reset("reset_mid_frame");
        send_frame(3'd6, 3, 96'h037F10, 0);
        get_result("max_after_reset", 16'h007F, 4'b0000, 0);
        send_frame(3'd1, 2, 96'h0201, 0);
        chk("resp_before_reset_data", 32'(bus.res_data), 32'h0003);
        pulse_reset("reset_in_resp");
        for (int k = 0; k < 40; k++) begin
            logic [2:0] op = 3'($urandom_range(0, 7));
            int n = $urandom_range(0, 11);
            for (int i = 0; i < 12; i++) r_ops[i] = 8'($urandom_range(0, 255));
            m = model(op, n, r_ops);
            send_frame(op, n, r_ops, 2);
            get_result($sformatf("rand%0d", k), m[19:4], m[3:0], $urandom_range(0, 2));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
